// File: rtl/cory_rr_arb.sv
// cory_rr_arb: packet-aware round-robin arbiter feeding a single-entry output register.
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   reset_n  - asynchronous active-low reset
//   i_a_v    - per-requester valid (bit k = requester k)
//   i_a_d    - per-requester data, requester k at [k*N +: N]
//   i_a_l    - per-requester last-beat flag, qualified by i_a_v
//   o_a_r    - per-requester ready (at most one bit set)
//   o_z_v    - output valid (stage full)
//   o_z_d    - output data
//   o_z_id   - index of the requester that supplied o_z_d
//   o_z_l    - last flag of the beat on o_z_d
//   i_z_r    - downstream ready
//
// A packet runs from the first beat a requester gets granted to its beat with l=1. While a
// packet is open the arbiter is locked to that requester, even if it drops valid, so beats of
// different packets never interleave. When a packet closes, the search pointer moves to the
// requester after the one just served.
module cory_rr_arb #(
    parameter int unsigned N   = 8,
    parameter int unsigned NUM = 4,
    parameter int unsigned W   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM-1:0]   i_a_v,
    input  logic [NUM*N-1:0] i_a_d,
    input  logic [NUM-1:0]   i_a_l,
    output logic [NUM-1:0]   o_a_r,
    output logic             o_z_v,
    output logic [N-1:0]     o_z_d,
    output logic [W-1:0]     o_z_id,
    output logic             o_z_l,
    input  logic             i_z_r
);

    typedef enum logic {StUnlocked, StLocked} state_e;

    state_e       state_q;
    logic [W-1:0] lock_id_q;
    logic [W-1:0] ptr_q;
    logic         full_q;
    logic [N-1:0] d_q;
    logic [W-1:0] id_q;
    logic         l_q;

    logic           gnt_found;
    logic [W-1:0]   gnt_id;
    logic [NUM-1:0] gnt_oh;
    logic           can_accept;
    logic           accept;
    logic           sel_v;
    logic           sel_l;
    logic [N-1:0]   sel_d;
    logic [W-1:0]   ptr_next;
    int unsigned    cand;

    // Grant selection: locked -> fixed id regardless of valid; unlocked -> first valid
    // requester at or after ptr, wrapping modulo NUM.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = 0;
        if (state_q == StLocked) begin
            gnt_found = 1'b1;
            gnt_id    = lock_id_q;
        end else begin
            for (int unsigned i = 0; i < NUM; i++) begin
                cand = 32'(ptr_q) + i;
                if (cand >= NUM) begin
                    cand = cand - NUM;
                end
                for (int unsigned k = 0; k < NUM; k++) begin
                    if (!gnt_found && (cand == k) && i_a_v[k]) begin
                        gnt_found = 1'b1;
                        gnt_id    = W'(k);
                    end
                end
            end
        end
    end

    // Stage can take a beat when empty, or when the held beat leaves this same cycle.
    assign can_accept = !full_q || i_z_r;

    always_comb begin
        gnt_oh = '0;
        sel_v  = 1'b0;
        sel_l  = 1'b0;
        sel_d  = '0;
        for (int unsigned k = 0; k < NUM; k++) begin
            gnt_oh[k] = gnt_found && (gnt_id == W'(k));
            sel_v     = sel_v | (i_a_v[k] & gnt_oh[k]);
            sel_l     = sel_l | (i_a_l[k] & gnt_oh[k]);
            sel_d     = sel_d | (i_a_d[k*N +: N] & {N{gnt_oh[k]}});
        end
    end

    assign o_a_r  = can_accept ? gnt_oh : '0;
    assign accept = can_accept && sel_v;

    // Explicit wrap so non-power-of-2 NUM returns to 0 after NUM-1.
    assign ptr_next = (gnt_id == W'(NUM - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StUnlocked;
            lock_id_q <= '0;
            ptr_q     <= '0;
            full_q    <= 1'b0;
            d_q       <= '0;
            id_q      <= '0;
            l_q       <= 1'b0;
        end else begin
            if (accept) begin
                full_q <= 1'b1;
                d_q    <= sel_d;
                id_q   <= gnt_id;
                l_q    <= sel_l;
                if (sel_l) begin
                    state_q <= StUnlocked;
                    ptr_q   <= ptr_next;
                end else begin
                    state_q   <= StLocked;
                    lock_id_q <= gnt_id;
                end
            end else if (full_q && i_z_r) begin
                full_q <= 1'b0;
            end
        end
    end

    assign o_z_v  = full_q;
    assign o_z_d  = d_q;
    assign o_z_id = id_q;
    assign o_z_l  = l_q;

endmodule
